pipeline_stall_ctrl: RTL and testbench

Central stall and flush sequencer for the 5-stage pipeline CPU. It merges the load-use stall request from the hazard-detection unit, data-cache miss waits from the MEM stage, and taken-branch flushes into one set of prioritised pipeline-register controls. It also runs a miss-wait watchdog and a stall-cycle performance counter. It sits between the hazard-detection unit, the dcache controller and the PC / IF/ID / ID/EX / EX/MEM / MEM/WB registers.

---
 rtl/pipeline_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges memory hold, load-use stall and branch flush into pipeline-register controls.
// Latency: control outputs are combinational (zero-cycle) from state and requests; state/counters update on clk_i rising edge.
// Backpressure: a dcache miss (hold) freezes the whole pipe and takes priority over load-use bubbles and branch flushes.
//
// Ports:
//   clk_i, rst_i (async active-low)   clock / reset
//   start_i                           CPU run enable (level)
//   hz_stall_i, branch_i              load-use stall request, taken branch in ID
//   mem_req_i, mem_ack_i              MEM-stage access pending / dcache completion
//   PCWrite_o, IFID_Write_o           PC and IF/ID write enables
//   IFID_Flush_o, IDEX_NoOp_o         IF/ID flush, ID/EX bubble insert
//   pipe_hold_o                       freeze ID/EX, EX/MEM, MEM/WB
//   err_o                             sticky miss-wait watchdog error
//   stall_cnt_o                       saturating stalled-cycle counter
module pipeline_stall_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             hz_stall_i,
    input  logic             branch_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_NoOp_o,
    output logic             pipe_hold_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    // hold_cnt_q holds the number of hold cycles already completed, so the
    // current hold cycle is number hold_cnt_q+1. The watchdog therefore fires
    // when the cycle that would make the total reach TIMEOUT is still a hold.
    localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [15:0]       hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic active;
    logic hold;
    logic wd_fire;

    assign active  = (state_q == S_RUN) || (state_q == S_MEM_WAIT);
    assign hold    = active && mem_req_i && !mem_ack_i;
    assign wd_fire = (state_q == S_MEM_WAIT) && hold && (hold_cnt_q == HOLD_LAST);

    // Control outputs, priority hold > load-use stall > branch flush.
    always_comb begin
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
        IFID_Flush_o = 1'b0;
        IDEX_NoOp_o  = 1'b0;
        pipe_hold_o  = 1'b0;
        if (!active || hold) begin
            // Not running, or waiting on the dcache: freeze everything.
            pipe_hold_o = 1'b1;
        end else if (hz_stall_i) begin
            // Branch operands are not ready while a load-use stall is
            // pending, so a same-cycle branch is ignored.
            IDEX_NoOp_o = 1'b1;
        end else if (branch_i) begin
            PCWrite_o    = 1'b1;
            IFID_Write_o = 1'b1;
            IFID_Flush_o = 1'b1;
        end else begin
            PCWrite_o    = 1'b1;
            IFID_Write_o = 1'b1;
        end
    end

    assign err_o       = (state_q == S_ERROR);
    assign stall_cnt_o = stall_cnt_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (hold)          state_d = S_MEM_WAIT;
                else if (!start_i) state_d = S_IDLE;
            end
            S_MEM_WAIT: begin
                // Completion is checked first so an ack on the timeout
                // cycle still returns to normal operation.
                if (mem_ack_i || !mem_req_i) state_d = start_i ? S_RUN : S_IDLE;
                else if (wd_fire)            state_d = S_ERROR;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d = 16'd0;
        if (hold) begin
            if (state_q == S_RUN) hold_cnt_d = 16'd1;
            else                  hold_cnt_d = hold_cnt_q + 16'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (active && !PCWrite_o && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= 16'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, hz = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
    logic       pcw, ifidw, flush, noop, phold, err;
    logic [2:0] cnt;

    pipeline_stall_ctrl #(.CNT_W(3), .TIMEOUT(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .hz_stall_i   (hz),
        .branch_i     (br),
        .mem_req_i    (req),
        .mem_ack_i    (ack),
        .PCWrite_o    (pcw),
        .IFID_Write_o (ifidw),
        .IFID_Flush_o (flush),
        .IDEX_NoOp_o  (noop),
        .pipe_hold_o  (phold),
        .err_o        (err),
        .stall_cnt_o  (cnt)
    );

    always #5 clk = ~clk;

    // Control vector order: {PCWrite, IFID_Write, IFID_Flush, IDEX_NoOp, pipe_hold, err}
    localparam logic [5:0] O_IDLE = 6'b000010;
    localparam logic [5:0] O_HOLD = 6'b000010;
    localparam logic [5:0] O_RUN  = 6'b110000;
    localparam logic [5:0] O_BR   = 6'b111000;
    localparam logic [5:0] O_HZ   = 6'b000100;
    localparam logic [5:0] O_ERR  = 6'b000011;

    typedef struct {
        string      nm;
        logic [8:0] exp;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected for that cycle.
    task automatic vec(input logic r, input logic s, input logic h, input logic b,
                       input logic rq, input logic ak, input string nm,
                       input logic [5:0] ctl, input logic [2:0] c);
        @(posedge clk);
        #1;
        rst = r; start = s; hz = h; br = b; req = rq; ack = ak;
        q.push_back('{nm, {ctl, c}});
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [8:0] act;
            e = q.pop_front();
            act = {pcw, ifidw, flush, noop, phold, err, cnt};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                         e.nm, act[8:3], act[2:0], e.exp[8:3], e.exp[2:0]);
            end
        end
    end

    initial begin
        //   rst st hz br rq ak  name            ctl     cnt
        vec(0, 1, 0, 0, 0, 0, "reset_state",   O_IDLE, 3'd0);
        vec(1, 1, 0, 0, 0, 0, "release_idle",  O_IDLE, 3'd0);
        vec(1, 1, 0, 0, 0, 0, "first_run",     O_RUN,  3'd0);
        vec(1, 1, 1, 1, 0, 0, "hz_over_br",    O_HZ,   3'd0);
        vec(1, 1, 0, 0, 0, 0, "after_hz",      O_RUN,  3'd1);
        vec(1, 1, 0, 1, 0, 0, "branch_flush",  O_BR,   3'd1);
        // 5-cycle access, ack in 5th cycle, load-use pending throughout;
        // ack coincides with the would-be timeout cycle.
        vec(1, 1, 1, 0, 1, 0, "miss_h1",       O_HOLD, 3'd1);
        vec(1, 1, 1, 0, 1, 0, "miss_h2",       O_HOLD, 3'd2);
        vec(1, 1, 1, 0, 1, 0, "miss_h3",       O_HOLD, 3'd3);
        vec(1, 1, 1, 0, 1, 0, "miss_h4",       O_HOLD, 3'd4);
        vec(1, 1, 1, 0, 1, 1, "miss_ack_hz",   O_HZ,   3'd5);
        vec(1, 1, 0, 0, 0, 0, "after_miss",    O_RUN,  3'd6);
        vec(1, 1, 0, 0, 1, 1, "hit_1cyc",      O_RUN,  3'd6);
        // Unacknowledged miss: error after the 5th hold cycle.
        vec(1, 1, 0, 0, 1, 0, "to_h1",         O_HOLD, 3'd6);
        vec(1, 1, 0, 0, 1, 0, "to_h2",         O_HOLD, 3'd7);
        vec(1, 1, 0, 0, 1, 0, "to_h3",         O_HOLD, 3'd7);
        vec(1, 1, 0, 0, 1, 0, "to_h4",         O_HOLD, 3'd7);
        vec(1, 1, 0, 0, 1, 0, "to_h5",         O_HOLD, 3'd7);
        vec(1, 1, 0, 0, 0, 0, "error_state",   O_ERR,  3'd7);
        vec(1, 1, 1, 1, 0, 0, "error_sticky",  O_ERR,  3'd7);
        vec(0, 1, 0, 0, 0, 0, "err_reset",     O_IDLE, 3'd0);
        vec(1, 1, 0, 0, 0, 0, "rel2_idle",     O_IDLE, 3'd0);
        vec(1, 1, 0, 0, 0, 0, "run2",          O_RUN,  3'd0);
        for (int i = 0; i < 10; i++)
            vec(1, 1, 1, 0, 0, 0, "sat_hz", O_HZ, (i > 7) ? 3'd7 : 3'(i));
        vec(1, 1, 0, 0, 0, 0, "sat_hold7",     O_RUN,  3'd7);
        // Reset in the middle of a miss wait.
        vec(1, 1, 0, 0, 1, 0, "mw_h1",         O_HOLD, 3'd7);
        vec(1, 1, 0, 0, 1, 0, "mw_h2",         O_HOLD, 3'd7);
        vec(0, 1, 0, 0, 1, 0, "mid_mw_reset",  O_IDLE, 3'd0);
        vec(1, 0, 0, 0, 1, 0, "idle_no_start", O_IDLE, 3'd0);
        vec(1, 1, 0, 0, 0, 0, "idle_start",    O_IDLE, 3'd0);
        vec(1, 0, 0, 0, 0, 0, "run_no_resid",  O_RUN,  3'd0);
        vec(1, 0, 0, 0, 0, 0, "run_to_idle",   O_IDLE, 3'd0);
        // start_i dropped during a miss: held until completion, then IDLE.
        vec(1, 1, 0, 0, 0, 0, "idle_start2",   O_IDLE, 3'd0);
        vec(1, 1, 0, 0, 1, 0, "stop_h1",       O_HOLD, 3'd0);
        vec(1, 0, 0, 0, 1, 0, "stop_h2",       O_HOLD, 3'd1);
        vec(1, 0, 0, 0, 1, 1, "stop_ack",      O_RUN,  3'd2);
        vec(1, 0, 0, 0, 0, 0, "stop_idle",     O_IDLE, 3'd2);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
